// File: rtl/pipe_skid_latch_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_latch_if
// Handshake bundle between two pipeline stages through a pipe_skid_latch.
//
// Signals:
//   in_valid        upstream offers an entry
//   in_ready        latch can take an entry this edge
//   in_instruction  upstream instruction     [INST_WIDTH]
//   in_pc_4         upstream PC+4            [PC_WIDTH]
//   out_valid       out_* carry a valid entry
//   out_ready       downstream consumes the head entry this edge
//   out_instruction head instruction         [INST_WIDTH]
//   out_pc_4        head PC+4                [PC_WIDTH]
//
// Modports:
//   master - the surrounding stages (drive in_* and out_ready)
//   slave  - the latch itself
// -----------------------------------------------------------------------------
interface pipe_skid_latch_if #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [INST_WIDTH-1:0] in_instruction;
    logic [PC_WIDTH-1:0]   in_pc_4;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_WIDTH-1:0] out_instruction;
    logic [PC_WIDTH-1:0]   out_pc_4;

    modport master (
        output in_valid,
        output in_instruction,
        output in_pc_4,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instruction,
        input  out_pc_4
    );

    modport slave (
        input  in_valid,
        input  in_instruction,
        input  in_pc_4,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instruction,
        output out_pc_4
    );
endinterface

// File: rtl/pipe_skid_latch.sv
// -----------------------------------------------------------------------------
// pipe_skid_latch
// Handshaked pipeline-stage register with a 2-entry skid buffer. The upstream
// ready is decoded from registered state only, so downstream back-pressure
// never forms a combinational path across stages. Supports per-stage flush
// (bubble insertion) and a global enable that freezes the stage.
//
// Optional feature macro: PIPE_LATCH_STATS_EN
//   When defined, adds saturating stall/flush statistics counters.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   i_cpu_en     global enable; 0 freezes all state except rst/flush
//   i_flush      discard all held entries this edge
//   bus          pipe_skid_latch_if.slave handshake bundle
//   o_stall_cnt  cycles with a valid head blocked downstream (macro only)
//   o_flush_cnt  flushes that discarded at least one entry (macro only)
// -----------------------------------------------------------------------------
module pipe_skid_latch #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    PC_WIDTH   = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cpu_en,
    input  logic i_flush,
    pipe_skid_latch_if.slave bus
`ifdef PIPE_LATCH_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_flush_cnt
`endif
);

    // Encoding chosen so bit 0 means "main valid" and bit 1 means "skid valid".
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    state_t                r_state;
    logic [INST_WIDTH-1:0] r_main_inst;
    logic [PC_WIDTH-1:0]   r_main_pc;
    logic [INST_WIDTH-1:0] r_skid_inst;
    logic [PC_WIDTH-1:0]   r_skid_pc;

    state_t                w_state_nxt;
    logic [INST_WIDTH-1:0] w_main_inst_nxt;
    logic [PC_WIDTH-1:0]   w_main_pc_nxt;
    logic [INST_WIDTH-1:0] w_skid_inst_nxt;
    logic [PC_WIDTH-1:0]   w_skid_pc_nxt;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_drain;

    // Handshake flags are pure decodes of the state register.
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_ready  = (r_state != ST_SKID);
    assign w_accept    = i_cpu_en & bus.in_valid & w_in_ready;
    assign w_drain     = i_cpu_en & w_out_valid & bus.out_ready;

    assign bus.out_valid       = w_out_valid;
    assign bus.in_ready        = w_in_ready;
    assign bus.out_instruction = r_main_inst;
    assign bus.out_pc_4        = r_main_pc;

    // Next-state and storage update selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_main_inst_nxt = r_main_inst;
        w_main_pc_nxt   = r_main_pc;
        w_skid_inst_nxt = r_skid_inst;
        w_skid_pc_nxt   = r_skid_pc;

        if (i_flush) begin
            // Flush wins over enable; a same-cycle drain was already sampled
            // downstream, and a same-cycle accept is simply dropped.
            w_state_nxt     = ST_EMPTY;
            w_main_inst_nxt = NOP_INST;
            w_main_pc_nxt   = {PC_WIDTH{1'b0}};
        end else if (i_cpu_en) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt     = ST_FULL;
                        w_main_inst_nxt = bus.in_instruction;
                        w_main_pc_nxt   = bus.in_pc_4;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_accept && w_drain) begin
                        w_state_nxt     = ST_FULL;
                        w_main_inst_nxt = bus.in_instruction;
                        w_main_pc_nxt   = bus.in_pc_4;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new entry behind main.
                        w_state_nxt     = ST_SKID;
                        w_skid_inst_nxt = bus.in_instruction;
                        w_skid_pc_nxt   = bus.in_pc_4;
                    end else if (w_drain) begin
                        w_state_nxt     = ST_EMPTY;
                        w_main_inst_nxt = NOP_INST;
                        w_main_pc_nxt   = {PC_WIDTH{1'b0}};
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the drain can happen.
                    if (w_drain) begin
                        w_state_nxt     = ST_FULL;
                        w_main_inst_nxt = r_skid_inst;
                        w_main_pc_nxt   = r_skid_pc;
                    end else begin
                        w_state_nxt = ST_SKID;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean bubble.
                    w_state_nxt     = ST_EMPTY;
                    w_main_inst_nxt = NOP_INST;
                    w_main_pc_nxt   = {PC_WIDTH{1'b0}};
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_inst <= NOP_INST;
            r_main_pc   <= {PC_WIDTH{1'b0}};
            r_skid_inst <= {INST_WIDTH{1'b0}};
            r_skid_pc   <= {PC_WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_main_inst <= w_main_inst_nxt;
            r_main_pc   <= w_main_pc_nxt;
            r_skid_inst <= w_skid_inst_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
        end
    end

`ifdef PIPE_LATCH_STATS_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic                 w_stall_evt;
    logic                 w_flush_evt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1'b1);
        end
    endfunction

    assign w_stall_evt = i_cpu_en & w_out_valid & ~bus.out_ready;
    assign w_flush_evt = i_flush & w_out_valid;

    // Saturating statistics counters; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {CNT_WIDTH{1'b0}};
            r_flush_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_stall_evt) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_evt) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
module tb_pipe_skid_latch;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_LATCH_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_en = 1'b0;
    logic flush = 1'b0;

    pipe_skid_latch_if #(.INST_WIDTH(32), .PC_WIDTH(32)) bus ();

`ifdef PIPE_LATCH_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    pipe_skid_latch #(
        .INST_WIDTH(32), .PC_WIDTH(32), .NOP_INST(NOP), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_cpu_en(cpu_en),
        .i_flush(flush),
        .bus(bus)
`ifdef PIPE_LATCH_STATS_EN
        ,
        .o_stall_cnt(stall_cnt),
        .o_flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a bounded FIFO of {inst, pc} with capacity 2.
    logic [63:0]      mq[$];
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    function automatic void model_step(input logic r, input logic en, input logic fl,
                                       input logic iv, input logic [31:0] inst,
                                       input logic [31:0] pc, input logic ordy);
        bit acc;
        bit drn;
        acc = en && iv && (mq.size() < 2);
        drn = en && (mq.size() > 0) && ordy;
        if (r) begin
            mq.delete();
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (en && mq.size() > 0 && !ordy && m_stall != CNT_MAX) m_stall = m_stall + 1'b1;
            if (fl && mq.size() > 0 && m_flush != CNT_MAX) m_flush = m_flush + 1'b1;
            if (fl) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back({inst, pc});
            end
        end
    endfunction

    // Drive one cycle, advance the model, then sample #1 after the edge.
    task automatic apply(input logic r, input logic en, input logic fl, input logic iv,
                         input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
        rst = r; cpu_en = en; flush = fl;
        bus.in_valid = iv; bus.in_instruction = inst; bus.in_pc_4 = pc; bus.out_ready = ordy;
        @(posedge clk);
        model_step(r, en, fl, iv, inst, pc, ordy);
        #1;
    endtask

    task automatic check4(input string name, input logic ov, input logic ir,
                          input logic [31:0] oi, input logic [31:0] opc);
        n_vec++;
        if (bus.out_valid !== ov || bus.in_ready !== ir ||
            bus.out_instruction !== oi || bus.out_pc_4 !== opc) begin
            n_bad++;
            $display("FAIL %s: got ov=%0b ir=%0b inst=%h pc=%h, expected ov=%0b ir=%0b inst=%h pc=%h",
                     name, bus.out_valid, bus.in_ready, bus.out_instruction, bus.out_pc_4,
                     ov, ir, oi, opc);
        end
    endtask

    task automatic check_model(input string name);
        logic [31:0] ei;
        logic [31:0] ep;
        ei = (mq.size() > 0) ? mq[0][63:32] : NOP;
        ep = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
        check4(name, mq.size() > 0, mq.size() < 2, ei, ep);
`ifdef PIPE_LATCH_STATS_EN
        n_vec++;
        if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
            n_bad++;
            $display("FAIL %s_cnt: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                     name, stall_cnt, flush_cnt, m_stall, m_flush);
        end
`endif
    endtask

    typedef struct {
        logic        rst, en, fl, iv;
        logic [31:0] inst, pc;
        logic        ordy;
        logic        ov, ir;
        logic [31:0] oi, opc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic en, input logic fl, input logic iv,
                                input logic [31:0] inst, input logic [31:0] pc, input logic ordy,
                                input logic ov, input logic ir,
                                input logic [31:0] oi, input logic [31:0] opc);
        vec_t v;
        v.rst = r; v.en = en; v.fl = fl; v.iv = iv; v.inst = inst; v.pc = pc; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.oi = oi; v.opc = opc;
        vecs.push_back(v);
    endfunction

    localparam logic [31:0] A = 32'h00A0_0093, B = 32'h00B0_0113, C = 32'h00C0_0193;
    localparam logic [31:0] D = 32'h00D0_0213, E = 32'h00E0_0293, F = 32'h00F0_0313;
    localparam logic [31:0] G = 32'h0100_0393, H = 32'h0110_0413;

    initial begin
        bus.in_valid = 1'b0; bus.in_instruction = 32'h0; bus.in_pc_4 = 32'h0; bus.out_ready = 1'b0;

        //   rst en fl iv inst pc   ordy | ov ir out  pc
        add(1, 0, 0, 0, 0, 0,  0,  0, 1, NOP, 0);   // reset
        add(0, 1, 0, 1, A, 4,  1,  1, 1, A,   4);   // streaming
        add(0, 1, 0, 1, B, 8,  1,  1, 1, B,   8);
        add(0, 1, 0, 1, C, 12, 1,  1, 1, C,   12);
        add(0, 1, 0, 0, 0, 0,  1,  0, 1, NOP, 0);   // drain to empty
        add(0, 1, 0, 1, A, 4,  0,  1, 1, A,   4);   // back-pressure
        add(0, 1, 0, 1, B, 8,  0,  1, 0, A,   4);   // B into skid
        add(0, 1, 0, 1, C, 12, 0,  1, 0, A,   4);   // C refused
        add(0, 1, 0, 1, C, 12, 1,  1, 1, B,   8);   // skid -> main, C still refused
        add(0, 1, 0, 1, C, 12, 1,  1, 1, C,   12);
        add(0, 1, 0, 0, 0, 0,  1,  0, 1, NOP, 0);
        add(0, 1, 0, 1, D, 16, 0,  1, 1, D,   16);  // fill to SKID
        add(0, 1, 0, 1, E, 20, 0,  1, 0, D,   16);
        add(0, 1, 1, 1, F, 24, 0,  0, 1, NOP, 0);   // flush in SKID drops F
        add(0, 1, 0, 1, G, 28, 0,  1, 1, G,   28);
        add(0, 0, 0, 1, H, 32, 1,  1, 1, G,   28);  // cpu_en low: frozen
        add(0, 0, 0, 1, H, 32, 1,  1, 1, G,   28);
        add(0, 0, 0, 1, H, 32, 1,  1, 1, G,   28);
        add(0, 0, 1, 1, H, 32, 1,  0, 1, NOP, 0);   // flush ignores cpu_en
        add(0, 1, 0, 1, H, 32, 0,  1, 1, H,   32);
        add(1, 1, 1, 1, A, 4,  1,  0, 1, NOP, 0);   // rst beats flush/accept
        add(0, 1, 0, 1, A, 4,  0,  1, 1, A,   4);
        add(0, 1, 0, 1, B, 8,  0,  1, 0, A,   4);
        add(1, 1, 0, 1, C, 12, 0,  0, 1, NOP, 0);   // rst mid-SKID
        add(0, 1, 0, 0, 0, 0,  1,  0, 1, NOP, 0);   // nothing left behind

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].fl, vecs[i].iv,
                  vecs[i].inst, vecs[i].pc, vecs[i].ordy);
            check4($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].oi, vecs[i].opc);
        end

        // Long downstream stall: only one entry absorbed beyond main.
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 32'h100, 32'h1, 0);
        apply(0, 1, 0, 1, 32'h101, 32'h2, 0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 0, 1, 32'h102, 32'h3, 0);
            check4($sformatf("stall_hold%0d", k), 1'b1, 1'b0, 32'h100, 32'h1);
        end
        apply(0, 1, 0, 1, 32'h102, 32'h3, 1);
        check4("stall_rel0", 1'b1, 1'b1, 32'h101, 32'h2);
        apply(0, 1, 0, 1, 32'h102, 32'h3, 1);
        check4("stall_rel1", 1'b1, 1'b1, 32'h102, 32'h3);
        apply(0, 1, 0, 0, 32'h0, 32'h0, 1);
        check4("stall_rel2", 1'b0, 1'b1, NOP, 32'h0);

`ifdef PIPE_LATCH_STATS_EN
        // Counter saturation and flush counting.
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 1, A, 4, 0);
        for (int k = 0; k < 20; k++) apply(0, 1, 0, 0, 0, 0, 0);
        n_vec++;
        if (stall_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL stall_sat: got %0d, expected 15", stall_cnt);
        end
        apply(0, 1, 0, 1, B, 8, 0);
        apply(0, 1, 1, 1, C, 12, 0);
        check4("stats_flush", 1'b0, 1'b1, NOP, 32'h0);
        n_vec++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL flush_cnt: got flush=%0d stall=%0d, expected flush=1 stall=15",
                     flush_cnt, stall_cnt);
        end
`endif

        // Randomised traffic against the FIFO model.
        apply(1, 0, 0, 0, 0, 0, 0);
        check_model("rnd_reset");
        for (int c = 0; c < 2000; c++) begin
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                  $urandom, $urandom, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            check_model($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_latch.md
# pipe_skid_latch

Parametrised, handshaked pipeline-stage register for the 5-stage core. It is the generalised successor of the fixed IF/ID latch and sits between any two stages (IF/ID, ID/EX, ...). A 2-entry skid buffer decouples the upstream ready from the downstream ready, so back-pressure never forms a combinational path across stages. It adds per-stage flush (bubble insertion) and an optional stall/flush statistics counter.

## Interface
- INST_WIDTH, 32, instruction field width
- PC_WIDTH, 32, PC+4 field width
- NOP_INST, 32'h0000_0013, value driven on out_instruction when empty, reset or flushed (addi x0,x0,0)
- CNT_WIDTH, 16, width of statistics counters (used only with the macro)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- cpu_en  in  1  global enable; 0 freezes all state except rst/flush
- flush  in  1  discard all held entries this edge
- in_valid  in  1  upstream has an entry
- in_ready  out  1  latch can accept; function of registered state only
- in_instruction  in  INST_WIDTH  upstream instruction
- in_pc_4  in  PC_WIDTH  upstream PC+4
- out_valid  out  1  out_* hold a valid entry
- out_ready  in  1  downstream consumes
- out_instruction  out  INST_WIDTH  head instruction
- out_pc_4  out  PC_WIDTH  head PC+4
- stall_cnt  out  CNT_WIDTH  only with PIPE_LATCH_STATS_EN
- flush_cnt  out  CNT_WIDTH  only with PIPE_LATCH_STATS_EN

## Operation
- accept = cpu_en & in_valid & in_ready; drain = cpu_en & out_valid & out_ready.
- Storage: main register (drives out_*) and skid register.
- States: EMPTY (none held), FULL (main valid), SKID (main and skid valid).
- in_ready = (state != SKID). out_valid = (state != EMPTY). Both are registered-state decodes with no combinational dependency on out_ready or in_valid.
- EMPTY: accept -> FULL, main <= in.
- FULL: accept & drain -> FULL, main <= in. accept & ~drain -> SKID, skid <= in. ~accept & drain -> EMPTY, main <= {NOP_INST, 0}. Otherwise hold.
- SKID: drain -> FULL, main <= skid. Otherwise hold. No accept is possible in this state.
- Ordering is strict FIFO; no entry is lost or duplicated.
- Flush has priority over everything except rst and acts regardless of cpu_en: state <= EMPTY, main <= {NOP_INST, 0}, skid contents are don't-care. A same-cycle accept is dropped. A same-cycle drain still completes downstream (the downstream stage sampled it).
- cpu_en = 0 with no rst/flush: all registers hold.

## Timing
- Reset (rst = 1 at posedge): state EMPTY, out_valid 0, in_ready 1, out_instruction NOP_INST, out_pc_4 0, skid cleared to 0, counters 0.
- Latency: accept at edge N appears on out_* after edge N. Throughput is 1 entry/cycle with out_ready held high.
- Downstream deassert for k cycles: at most 1 extra entry is absorbed, then in_ready drops after the edge that fills the skid.
- rst mid-SKID discards both entries. rst overrides flush and cpu_en.

## Configuration
- PIPE_LATCH_STATS_EN defined: stall_cnt increments each cycle with cpu_en & out_valid & ~out_ready. flush_cnt increments on each flush edge where state != EMPTY. Both counters saturate at all-ones, clear on rst only, and are unaffected by flush.
- Not defined: stall_cnt/flush_cnt ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset: rst = 1 for 1 edge -> out_valid 0, in_ready 1, out_instruction 0x00000013, out_pc_4 0.
- Streaming: out_ready = 1, in_valid = 1, instructions 0x00A00093, 0x00B00113, 0x00C00193 on consecutive cycles -> each appears one cycle later, in order, out_valid continuously 1.
- Back-pressure: stream A, B, C with out_ready = 0 from cycle 2 -> A held, B in skid, in_ready 0, C not accepted. Raise out_ready -> A, B, C delivered in order with no loss.
- Flush in SKID: state SKID, flush = 1 with in_valid = 1 -> next cycle out_valid 0, in_ready 1, out_instruction 0x00000013; the offered entry is dropped. With the macro, flush_cnt = 1.
- cpu_en = 0 for 3 cycles with in_valid = out_ready = 1 -> no state change. Then flush with cpu_en = 0 -> still empties.
- Stats (macro on, CNT_WIDTH = 4): hold out_valid 1, out_ready 0 for 20 cycles -> stall_cnt saturates at 15.
